// File: rtl/fir_pkg.sv
// Shared defaults and controller state encoding for the FIR control slice.
package fir_pkg;

   localparam int unsigned FIR_D_W    = 12;
   localparam int unsigned FIR_C_W    = 12;
   localparam int unsigned FIR_N_TAPS = 16;
   localparam int unsigned FIR_LAT    = 2;

   typedef enum logic [1:0] {
      ST_LOAD  = 2'd0,
      ST_FLUSH = 2'd1,
      ST_RUN   = 2'd2
   } fir_state_e;

endpackage

// File: rtl/fir_ctrl_if.sv
// Handshake and datapath bus between the FIR controller and its surroundings.
interface fir_ctrl_if
   import fir_pkg::*;
#(
   parameter int unsigned D_W    = FIR_D_W,
   parameter int unsigned C_W    = FIR_C_W,
   parameter int unsigned N_TAPS = FIR_N_TAPS
);
   localparam int unsigned A_W = $clog2(N_TAPS);

   logic           cfg_valid;
   logic           cfg_ready;
   logic [A_W-1:0] cfg_addr;
   logic [C_W-1:0] cfg_data;
   logic           cfg_last;
   logic           s_valid;
   logic           s_ready;
   logic [D_W-1:0] s_data;
   logic           m_valid;
   logic [D_W-1:0] m_data;
   logic           fir_ce;
   logic [D_W-1:0] fir_in;
   logic [D_W-1:0] fir_out;
   logic           coef_we;
   logic [A_W-1:0] coef_addr;
   logic [C_W-1:0] coef_data;
   logic           busy;

   // Controller side.
   modport slave (
      input  cfg_valid, cfg_addr, cfg_data, cfg_last, s_valid, s_data, fir_out,
      output cfg_ready, s_ready, m_valid, m_data, fir_ce, fir_in,
             coef_we, coef_addr, coef_data, busy
   );

   // Source / sink / datapath side.
   modport master (
      output cfg_valid, cfg_addr, cfg_data, cfg_last, s_valid, s_data, fir_out,
      input  cfg_ready, s_ready, m_valid, m_data, fir_ce, fir_in,
             coef_we, coef_addr, coef_data, busy
   );

endinterface

// File: rtl/fir_valid_pipe.sv
// Tag delay line that tracks which datapath slots hold real samples; advances only on ce.
module fir_valid_pipe
   import fir_pkg::*;
#(
   parameter int unsigned LAT = FIR_LAT
)(
   input  logic clock,
   input  logic reset_n,
   input  logic ce,
   input  logic tag_in,
   output logic tag_out
);

   logic [LAT-1:0] pipe_q;

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         pipe_q <= '0;
      end else if (ce) begin
         pipe_q[0] <= tag_in;
         for (int unsigned i = 1; i < LAT; i++) begin
            pipe_q[i] <= pipe_q[i-1];
         end
      end
   end

   assign tag_out = pipe_q[LAT-1];

endmodule

// File: rtl/fir_ctrl.sv
// FIR controller: sequences coefficient loads, pipeline flushes and sample flow
// around an external MAC datapath.
module fir_ctrl
   import fir_pkg::*;
#(
   parameter int unsigned D_W    = FIR_D_W,
   parameter int unsigned C_W    = FIR_C_W,
   parameter int unsigned N_TAPS = FIR_N_TAPS,
   parameter int unsigned LAT    = FIR_LAT
)(
   input  logic      clock,
   input  logic      reset_n,
   fir_ctrl_if.slave bus
);

   localparam int unsigned FLUSH_LEN = N_TAPS + LAT;
   localparam int unsigned CNT_W     = $clog2(FLUSH_LEN + 1);

   fir_state_e       state_q;
   logic [CNT_W-1:0] flush_cnt_q;
   logic             m_valid_q;
   logic [D_W-1:0]   m_data_q;
   logic [C_W-1:0]   coef_data;
   logic             in_run;
   logic             in_flush;
   logic             in_load;
   logic             xfer;
   logic             tag_out;
   logic             emit;

   always_comb begin
      in_run        = (state_q == ST_RUN);
      in_flush      = (state_q == ST_FLUSH);
      in_load       = (state_q == ST_LOAD);
      xfer          = in_run && bus.s_valid && !bus.cfg_valid;
      coef_data     = bus.cfg_data;

      bus.s_ready   = in_run && !bus.cfg_valid;
      bus.cfg_ready = in_load;
      bus.coef_we   = in_load && bus.cfg_valid;
      bus.coef_addr = bus.cfg_addr;
      bus.coef_data = coef_data;
      bus.fir_ce    = in_flush || xfer;
      bus.fir_in    = xfer ? bus.s_data : '0;
      bus.busy      = !in_run;
      bus.m_valid   = m_valid_q;
      bus.m_data    = m_data_q;

      // Stale tags left by a LOAD are shifted out within the first LAT flush
      // cycles, so restricting emission to RUN equals clearing them on entry.
      emit          = bus.fir_ce && tag_out && in_run;
   end

   fir_valid_pipe #(.LAT(LAT)) u_valid_pipe (
      .clock   (clock),
      .reset_n (reset_n),
      .ce      (bus.fir_ce),
      .tag_in  (xfer),
      .tag_out (tag_out)
   );

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q     <= ST_FLUSH;
         flush_cnt_q <= '0;
      end else begin
         case (state_q)
            ST_FLUSH: begin
               if (flush_cnt_q == CNT_W'(FLUSH_LEN - 1)) begin
                  state_q     <= ST_RUN;
                  flush_cnt_q <= '0;
               end else begin
                  flush_cnt_q <= flush_cnt_q + 1'b1;
               end
            end
            ST_RUN: begin
               if (bus.cfg_valid) state_q <= ST_LOAD;
            end
            ST_LOAD: begin
               if (bus.cfg_valid && bus.cfg_last) begin
                  state_q     <= ST_FLUSH;
                  flush_cnt_q <= '0;
               end
            end
            default: begin
               state_q     <= ST_FLUSH;
               flush_cnt_q <= '0;
            end
         endcase
      end
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         m_valid_q <= 1'b0;
         m_data_q  <= '0;
      end else begin
         m_valid_q <= emit;
         if (emit) m_data_q <= bus.fir_out;
      end
   end

endmodule

// File: tb/tb_fir_ctrl.sv
// Bench for fir_ctrl: behavioural FIR reference with per-cycle output checks plus directed scenarios.
module tb_fir_ctrl;
   import fir_pkg::*;

   localparam int D_W    = FIR_D_W;
   localparam int C_W    = FIR_C_W;
   localparam int N_TAPS = FIR_N_TAPS;
   localparam int LAT    = FIR_LAT;
   localparam int A_W    = $clog2(N_TAPS);
   localparam int FLEN   = N_TAPS + LAT;

   logic clock   = 1'b0;
   logic reset_n = 1'b1;
   always #5 clock = ~clock;

   fir_ctrl_if #(.D_W(D_W), .C_W(C_W), .N_TAPS(N_TAPS)) bus ();

   fir_ctrl #(.D_W(D_W), .C_W(C_W), .N_TAPS(N_TAPS), .LAT(LAT)) dut (
      .clock   (clock),
      .reset_n (reset_n),
      .bus     (bus)
   );

   int tests = 0;
   int fails = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- datapath stand-in: plain FIR with LAT-deep result pipe
   logic signed [C_W-1:0] dp_h [N_TAPS];
   logic signed [D_W-1:0] dp_x [N_TAPS];
   logic [D_W-1:0]        dp_r [LAT];
   int dp_acc;

   initial begin
      for (int i = 0; i < N_TAPS; i++) begin dp_h[i] = '0; dp_x[i] = '0; end
      for (int i = 0; i < LAT; i++) dp_r[i] = '0;
   end

   always @(posedge clock) begin
      if (bus.coef_we) dp_h[bus.coef_addr] <= bus.coef_data;
      if (bus.fir_ce) begin
         dp_acc = int'(dp_h[0]) * int'($signed(bus.fir_in));
         for (int i = 1; i < N_TAPS; i++) dp_acc += int'(dp_h[i]) * int'(dp_x[i-1]);
         dp_x[0] <= bus.fir_in;
         for (int i = 1; i < N_TAPS; i++) dp_x[i] <= dp_x[i-1];
         dp_r[0] <= D_W'(dp_acc);
         for (int i = 1; i < LAT; i++) dp_r[i] <= dp_r[i-1];
      end
   end
   assign bus.fir_out = dp_r[LAT-1];

   // ---------------- reference model
   typedef enum {M_FLUSH, M_RUN, M_LOAD} mode_t;
   typedef struct {int y; int k;} pend_t;

   mode_t          mode   = M_FLUSH;
   int             fcnt   = 0;
   int             ce_idx = 0;
   bit             exp_mv = 1'b0;
   logic [D_W-1:0] exp_md = '0;
   int             ref_h [N_TAPS] = '{default: 0};
   int             ref_x [N_TAPS] = '{default: 0};
   pend_t          pend [$];
   bit             m_ce, m_acc;
   int             m_y;

   always @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         mode   = M_FLUSH;
         fcnt   = 0;
         exp_mv = 1'b0;
         pend.delete();
      end else begin
         m_ce  = 1'b0;
         m_acc = 1'b0;
         case (mode)
            M_FLUSH: begin
               m_ce = 1'b1;
               if (fcnt == FLEN - 1) mode = M_RUN;
               else fcnt++;
            end
            M_RUN: begin
               if (bus.cfg_valid) mode = M_LOAD;
               else if (bus.s_valid) begin m_ce = 1'b1; m_acc = 1'b1; end
            end
            M_LOAD: begin
               if (bus.cfg_valid) begin
                  ref_h[bus.cfg_addr] = int'($signed(bus.cfg_data));
                  if (bus.cfg_last) begin
                     mode = M_FLUSH;
                     fcnt = 0;
                     pend.delete();
                  end
               end
            end
         endcase
         exp_mv = 1'b0;
         if (m_ce) begin
            ce_idx++;
            if (pend.size() > 0 && pend[0].k + LAT == ce_idx) begin
               exp_mv = 1'b1;
               exp_md = D_W'(pend[0].y);
               void'(pend.pop_front());
            end
            for (int i = N_TAPS - 1; i > 0; i--) ref_x[i] = ref_x[i-1];
            ref_x[0] = m_acc ? int'($signed(bus.s_data)) : 0;
            if (m_acc) begin
               m_y = 0;
               for (int i = 0; i < N_TAPS; i++) m_y += ref_h[i] * ref_x[i];
               pend.push_back('{y: m_y, k: ce_idx});
            end
         end
      end
   end

   // ---------------- per-cycle compare
   logic [D_W-1:0] seen [$];
   int             mv_total = 0;
   bit             e_xfer;

   always @(negedge clock) begin
      e_xfer = (mode == M_RUN) && !bus.cfg_valid && bus.s_valid;
      chk("s_ready",   bus.s_ready,   (mode == M_RUN) && !bus.cfg_valid);
      chk("cfg_ready", bus.cfg_ready, mode == M_LOAD);
      chk("busy",      bus.busy,      mode != M_RUN);
      chk("fir_ce",    bus.fir_ce,    (mode == M_FLUSH) || e_xfer);
      if (mode == M_FLUSH) chk("fir_in_flush", bus.fir_in, 0);
      if (e_xfer)          chk("fir_in_xfer",  bus.fir_in, bus.s_data);
      chk("coef_we", bus.coef_we, (mode == M_LOAD) && bus.cfg_valid);
      if (bus.coef_we) begin
         chk("coef_addr", bus.coef_addr, bus.cfg_addr);
         chk("coef_data", bus.coef_data, bus.cfg_data);
      end
      chk("m_valid", bus.m_valid, exp_mv);
      if (bus.m_valid && exp_mv) chk("m_data", bus.m_data, exp_md);
      if (!reset_n) chk("m_data_rst", bus.m_data, 0);
      if (bus.m_valid) begin
         seen.push_back(bus.m_data);
         mv_total++;
      end
   end

   // ---------------- stimulus helpers
   int ld_addr [N_TAPS];
   int ld_data [N_TAPS];

   task automatic idle(input int n);
      bus.s_valid   = 1'b0;
      bus.cfg_valid = 1'b0;
      repeat (n) @(posedge clock);
      #1;
   endtask

   task automatic send(input logic [D_W-1:0] d);
      bit ok = 1'b0;
      int n  = 0;
      bus.s_valid = 1'b1;
      bus.s_data  = d;
      while (!ok && n < 100) begin
         @(negedge clock);
         ok = bus.s_ready;
         @(posedge clock);
         #1;
         n++;
      end
      if (!ok) chk("send_timeout", 0, 1);
   endtask

   task automatic do_load(input int nw, input bit fin);
      for (int w = 0; w < nw; w++) begin
         bit ok = 1'b0;
         int n  = 0;
         bus.cfg_valid = 1'b1;
         bus.cfg_addr  = A_W'(ld_addr[w]);
         bus.cfg_data  = C_W'(ld_data[w]);
         bus.cfg_last  = fin && (w == nw - 1);
         while (!ok && n < 100) begin
            @(negedge clock);
            ok = bus.cfg_ready;
            @(posedge clock);
            #1;
            n++;
         end
         if (!ok) chk("cfg_timeout", 0, 1);
      end
      bus.cfg_valid = 1'b0;
      bus.cfg_last  = 1'b0;
   endtask

   task automatic wait_ready(output int n);
      n = 0;
      do begin
         @(posedge clock);
         #1;
         n++;
      end while (!bus.s_ready && n < 200);
   endtask

   // ---------------- directed scenarios then random traffic
   int n, base, base_mv, gap;

   initial begin
      bus.cfg_valid = 1'b0; bus.cfg_addr = '0; bus.cfg_data = '0; bus.cfg_last = 1'b0;
      bus.s_valid   = 1'b0; bus.s_data   = '0;

      #1 reset_n = 1'b0;
      #1 chk("rst_fir_ce", bus.fir_ce, 1);
      chk("rst_busy", bus.busy, 1);
      repeat (3) @(posedge clock);
      #1 reset_n = 1'b1;
      wait_ready(n);
      chk("ready_after_reset", n, FLEN);
      chk("busy_in_run", bus.busy, 0);
      chk("no_early_mv", mv_total, 0);

      // impulse response: output must equal input
      for (int i = 0; i < N_TAPS; i++) begin ld_addr[i] = i; ld_data[i] = (i == 0) ? 1 : 0; end
      do_load(N_TAPS, 1'b1);
      wait_ready(n);
      chk("flush_len_load", n, FLEN);
      base = seen.size();
      send(12'h7FF);
      send(12'h000);
      send(D_W'($urandom));
      send(D_W'($urandom));
      idle(1);
      chk("impulse_count", seen.size() - base, 2);
      if (seen.size() >= base + 2) begin
         chk("impulse_first",  seen[base],     12'h7FF);
         chk("impulse_second", seen[base + 1], 12'h000);
      end

      // random coefficients, samples with idle gaps
      for (int i = 0; i < N_TAPS; i++) ld_data[i] = int'($urandom_range(0, 4095));
      do_load(N_TAPS, 1'b1);
      wait_ready(n);
      chk("flush_len_rand", n, FLEN);
      base_mv = mv_total;
      for (int i = 0; i < 12; i++) begin
         send(D_W'($urandom));
         gap = int'($urandom_range(0, 5));
         if (gap > 0) idle(gap);
      end
      idle(1);
      chk("gap_pulses", mv_total - base_mv, 12 - LAT);

      // cfg and sample requested together: cfg wins
      for (int i = 0; i < 3; i++) begin ld_addr[i] = 2 * i; ld_data[i] = int'($urandom_range(0, 4095)); end
      bus.s_valid = 1'b1;
      bus.s_data  = D_W'($urandom);
      do_load(3, 1'b1);
      bus.s_valid = 1'b0;
      wait_ready(n);
      chk("flush_len_collide", n, FLEN);

      // reset in the middle of a load
      for (int i = 0; i < 5; i++) begin ld_addr[i] = i + 3; ld_data[i] = int'($urandom_range(0, 4095)); end
      do_load(5, 1'b0);
      bus.cfg_valid = 1'b1;
      bus.cfg_addr  = A_W'(9);
      #1 reset_n = 1'b0;
      #1 chk("we_async_rst", bus.coef_we, 0);
      chk("busy_async_rst", bus.busy, 1);
      @(posedge clock);
      #1;
      reset_n       = 1'b1;
      bus.cfg_valid = 1'b0;
      wait_ready(n);
      chk("ready_after_mid_rst", n, FLEN);

      // random traffic including occasional asynchronous reset pulses
      repeat (800) begin
         bus.s_valid   = $urandom_range(0, 1) == 1;
         bus.s_data    = D_W'($urandom);
         bus.cfg_valid = $urandom_range(0, 11) == 0;
         bus.cfg_last  = $urandom_range(0, 1) == 1;
         bus.cfg_addr  = A_W'($urandom);
         bus.cfg_data  = C_W'($urandom);
         if ($urandom_range(0, 249) == 0) begin
            #1 reset_n = 1'b0;
            #1 reset_n = 1'b1;
         end
         @(posedge clock);
         #1;
      end
      idle(5);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
      $fatal(1, "watchdog");
   end

endmodule
